// File: rtl/sat_narrow_stream.sv
// sat_narrow_stream: saturating signed IN_W->OUT_W narrowing stage with a
// 2-entry skid buffer on valid/ready and saturation statistics.
module sat_narrow_stream #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_count,
    input  logic             clr
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             r_state, w_next;
    logic               r_in_ready, r_out_valid;
    logic [OUT_W-1:0]   r_main_data, r_skid_data;
    logic               r_main_sat, r_skid_sat;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_cnt;
    logic [IN_W-OUT_W:0] w_hi;
    logic               w_sat, w_acc, w_otx;
    logic [OUT_W-1:0]   w_res;

    // The word fits when every bit from the narrow sign bit upward is the same.
    always_comb begin
        w_hi  = in_data[IN_W-1:OUT_W-1];
        w_sat = !((&w_hi) || !(|w_hi));
        w_res = !w_sat ? in_data[OUT_W-1:0] :
                in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        w_acc = in_valid && r_in_ready;
        w_otx = r_out_valid && out_ready;
        w_next = r_state == EMPTY ? (w_acc ? ONE : EMPTY) :
                 r_state == ONE   ? ((w_acc && !w_otx) ? TWO : (!w_acc && w_otx) ? EMPTY : ONE) :
                                    (w_otx ? ONE : TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_data <= '0;
            r_main_sat  <= 1'b0;
            r_skid_data <= '0;
            r_skid_sat  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= w_next != TWO;
            r_out_valid <= w_next != EMPTY;
            if ((r_state == EMPTY && w_acc) || (r_state == ONE && w_acc && w_otx)) begin
                r_main_data <= w_res;
                r_main_sat  <= w_sat;
            end else if (r_state == TWO && w_otx) begin
                r_main_data <= r_skid_data;
                r_main_sat  <= r_skid_sat;
            end
            if (r_state == ONE && w_acc && !w_otx) begin
                r_skid_data <= w_res;
                r_skid_sat  <= w_sat;
            end
        end
    end

    // A saturating accept in the same cycle as clr counts as the first event after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (clr) begin
            r_cnt    <= (w_acc && w_sat) ? CNT_W'(1) : '0;
            r_sticky <= w_acc && w_sat;
        end else if (w_acc && w_sat) begin
            r_cnt    <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            r_sticky <= 1'b1;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_main_data;
    assign out_sat    = r_main_sat;
    assign sat_sticky = r_sticky;
    assign sat_count  = r_cnt;
endmodule

// File: tb/tb_sat_narrow_stream.sv
// tb_sat_narrow_stream: directed and randomized checks of the saturating narrowing stream
// (a second instance with CNT_W=2 covers counter saturation).
module tb_sat_narrow_stream;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_sat, sat_sticky;
    logic [15:0] out_data, sat_count;
    logic        in_ready2, out_valid2, out_sat2, sat_sticky2;
    logic [15:0] out_data2;
    logic [1:0]  sat_count2;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    sat_narrow_stream #(.IN_W(32), .OUT_W(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_sticky(sat_sticky), .sat_count(sat_count), .clr(clr));

    sat_narrow_stream #(.IN_W(32), .OUT_W(16), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2),
        .sat_sticky(sat_sticky2), .sat_count(sat_count2), .clr(clr));

    function automatic logic [16:0] ref_nar(input logic [31:0] d);
        if ($signed(d) > 32'sd32767) return {1'b1, 16'h7fff};
        if ($signed(d) < -32'sd32768) return {1'b1, 16'h8000};
        return {1'b0, d[15:0]};
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r;
        int s;
        r = $urandom();
        s = $urandom_range(0, 3);
        return s == 0 ? r :
               s == 1 ? {{16{r[15]}}, r[15:0]} :
               s == 2 ? 32'h00008004 - {29'b0, r[2:0]} :
                        32'hffff8004 - {29'b0, r[2:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({out_valid, in_ready, out_data, out_sat, sat_sticky, sat_count} !== {1'b1 ^ 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0}) begin
            fails++;
            $display("FAIL reset: got v=%b r=%b d=%h s=%b st=%b c=%0d expected v=0 r=1 d=0 s=0 st=0 c=0",
                     out_valid, in_ready, out_data, out_sat, sat_sticky, sat_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_narrow();
        logic [31:0] vin [6] = '{32'h00007fff, 32'h00008000, 32'hffff8000, 32'hffff7fff, 32'h80000000, 32'h00000005};
        logic [15:0] eo  [6] = '{16'h7fff, 16'h7fff, 16'h8000, 16'h8000, 16'h8000, 16'h0005};
        logic        es  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vin[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, out_data, out_sat} !== {1'b1, 1'b1, eo[k], es[k]}) begin
                fails++;
                $display("FAIL narrow[%0d]: got v=%b r=%b d=%h s=%b expected v=1 r=1 d=%h s=%b",
                         k, out_valid, in_ready, out_data, out_sat, eo[k], es[k]);
            end
            if (k < 5) in_data = vin[k+1];
            else in_valid = 1'b0;
        end
        tests++;
        if (sat_count !== 16'd3 || sat_sticky !== 1'b1) begin
            fails++;
            $display("FAIL narrow_stats: got c=%0d st=%b expected c=3 st=1", sat_count, sat_sticky);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL narrow_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic        ev [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        er [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] ed [6] = '{16'h0011, 16'h0011, 16'h0011, 16'h0022, 16'h0033, 16'h7fff};
        logic        es [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00000011;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, out_data, out_sat} !== {ev[k], er[k], ed[k], es[k]}) begin
                fails++;
                $display("FAIL backpressure[%0d]: got v=%b r=%b d=%h s=%b expected v=%b r=%b d=%h s=%b",
                         k, out_valid, in_ready, out_data, out_sat, ev[k], er[k], ed[k], es[k]);
            end
            if (k == 0) in_data = 32'h00000022;
            if (k == 1) in_data = 32'h00000033;
            if (k == 2) out_ready = 1'b1;
            if (k == 4) in_data = 32'h12345678;
            if (k == 5) in_valid = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_drain: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_sat_count();
        logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clr = 1'b1;
        @(negedge clk);
        tests++;
        if ({sat_count2, sat_sticky2, sat_count, sat_sticky} !== {2'd0, 1'b0, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL clr_start: got c2=%0d st2=%b c=%0d st=%b expected all 0", sat_count2, sat_sticky2, sat_count, sat_sticky);
        end
        clr       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h80000000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if ({sat_count2, sat_sticky2, sat_count} !== {ec[k], 1'b1, 16'(k + 1)}) begin
                fails++;
                $display("FAIL cnt_sat[%0d]: got c2=%0d st2=%b c=%0d expected c2=%0d st2=1 c=%0d",
                         k, sat_count2, sat_sticky2, sat_count, ec[k], k + 1);
            end
        end
        in_valid = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        tests++;
        if ({sat_count2, sat_sticky2, sat_count, sat_sticky} !== {2'd0, 1'b0, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL clr_alone: got c2=%0d st2=%b c=%0d st=%b expected all 0", sat_count2, sat_sticky2, sat_count, sat_sticky);
        end
        in_valid = 1'b1;
        in_data  = 32'h7fffffff;
        @(negedge clk);
        tests++;
        if ({sat_count2, sat_sticky2, sat_count, sat_sticky, out_data, out_sat} !== {2'd1, 1'b1, 16'd1, 1'b1, 16'h7fff, 1'b1}) begin
            fails++;
            $display("FAIL clr_with_sat: got c2=%0d st2=%b c=%0d st=%b d=%h s=%b expected c2=1 st2=1 c=1 st=1 d=7fff s=1",
                     sat_count2, sat_sticky2, sat_count, sat_sticky, out_data, out_sat);
        end
        clr      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [16:0] q[$];
        logic [16:0] e;
        int sent = 0, cyc = 0;
        while ((sent < 10000 || q.size() > 0) && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            tests++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
                fails++;
                $display("FAIL random_flow@%0d: got r=%b v=%b expected occupancy %0d", cyc, in_ready, out_valid, q.size());
            end
            in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 3) != 0;
            in_data   = gen();
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL random_extra@%0d: got d=%h expected no word", cyc, out_data);
                end else begin
                    e = q.pop_front();
                    if ({out_sat, out_data} !== e) begin
                        fails++;
                        $display("FAIL random_data@%0d: got s=%b d=%h expected s=%b d=%h", cyc, out_sat, out_data, e[16], e[15:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_nar(in_data));
                sent++;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (cyc >= 70000) begin
            fails++;
            $display("FAIL random_timeout: got sent=%0d pending=%0d expected 10000 and 0", sent, q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h80000000;
        @(negedge clk);
        in_data = 32'h7fffffff;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sat_count === 16'd0) begin
            fails++;
            $display("FAIL reset_mid_pre: got r=%b v=%b c=%0d expected r=0 v=1 c>0", in_ready, out_valid, sat_count);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, out_data, out_sat, sat_sticky, sat_count, sat_count2, sat_sticky2} !==
            {1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: got v=%b r=%b d=%h s=%b st=%b c=%0d c2=%0d st2=%b expected v=0 r=1 d=0 s=0 st=0 c=0 c2=0 st2=0",
                     out_valid, in_ready, out_data, out_sat, sat_sticky, sat_count, sat_count2, sat_sticky2);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_ghost[%0d]: got v=%b v2=%b expected 0", k, out_valid, out_valid2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_backpressure();
        test_sat_count();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
